// File: rtl/conv_seq_ctrl_if.sv
// Handshake and ROM/bank bus between the conv sequencer and its surrounding
// datapath (weight/bias ROMs, window fetch, MAC, output buffer).
interface conv_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int KSIZE  = 5
);
  logic                            start;
  logic                            out_ready;
  logic [7:0]                      w_addr;
  logic [DATA_W-1:0]               w_rdata;
  logic [2:0]                      b_addr;
  logic [DATA_W-1:0]               b_rdata;
  logic [KSIZE*KSIZE*DATA_W-1:0]   weight_flat;
  logic [DATA_W-1:0]               bias_out;
  logic [2:0]                      filter_idx;
  logic [9:0]                      win_base;
  logic                            win_valid;
  logic                            adv;
  logic [12:0]                     out_addr;
  logic                            out_valid;
  logic                            busy;
  logic                            done;

  modport master (
    input  start, out_ready, w_rdata, b_rdata,
    output w_addr, b_addr, weight_flat, bias_out, filter_idx,
           win_base, win_valid, adv, out_addr, out_valid, busy, done
  );

  modport slave (
    output start, out_ready, w_rdata, b_rdata,
    input  w_addr, b_addr, weight_flat, bias_out, filter_idx,
           win_base, win_valid, adv, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer for the 5x5 conv MAC: per filter, loads weights/bias from
// ROM, scans all output positions and delays the output address to the result.
module conv_seq_ctrl #(
  parameter int DATA_W     = 32,
  parameter int IMG_W      = 32,
  parameter int KSIZE      = 5,
  parameter int NUM_FILTER = 6,
  parameter int OUT_ROW    = 28,
  parameter int OUT_COL    = 28,
  parameter int LAT        = 2
) (
  input logic             clk,
  input logic             rst_n,
  conv_seq_ctrl_if.master bus
);
  localparam int KK    = KSIZE * KSIZE;
  localparam int PLANE = OUT_ROW * OUT_COL;
  localparam int DW    = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        n;
  logic [4:0]        k, x, y;
  logic [DW-1:0]     dcnt;
  logic [DATA_W-1:0] wbank [KK];
  logic [DATA_W-1:0] bias_q;
  logic [LAT-1:0]    dv;
  logic [12:0]       da [LAT];

  logic        adv, issue;
  logic        last_y, last_pos, drain_end, last_filter;
  logic [12:0] issue_addr;

  assign last_y      = (y == 5'(OUT_COL - 1));
  assign last_pos    = last_y && (x == 5'(OUT_ROW - 1));
  assign drain_end   = (dcnt == DW'(LAT - 1));
  assign last_filter = (n == 3'(NUM_FILTER - 1));
  assign issue_addr  = 13'(n) * 13'(PLANE) + 13'(x) * 13'(OUT_COL) + 13'(y);

  always_comb begin
    adv = 1'b0;
    if (state == SCAN || state == DRAIN) adv = bus.out_ready;
  end
  assign issue = (state == SCAN) && adv;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (k == 5'(KK)) state_nxt = SCAN;
      SCAN:    if (adv && last_pos) state_nxt = DRAIN;
      DRAIN:   if (adv && drain_end) state_nxt = last_filter ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.adv         = adv;
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.win_valid   = issue;
    bus.win_base    = '0;
    bus.w_addr      = '0;
    bus.b_addr      = n;
    bus.filter_idx  = n;
    bus.bias_out    = bias_q;
    bus.out_valid   = dv[LAT-1];
    bus.out_addr    = da[LAT-1];
    bus.weight_flat = '0;
    if (state == SCAN) bus.win_base = 10'(x) * 10'(IMG_W) + 10'(y);
    if (state == LOAD && k < 5'(KK)) bus.w_addr = 8'(n) * 8'(KK) + 8'(k);
    for (int unsigned i = 0; i < KK; i++)
      bus.weight_flat[DATA_W*i +: DATA_W] = wbank[i];
  end

  // ROM data lags its address by one cycle, so step k captures weight k-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n      <= '0;
      k      <= '0;
      x      <= '0;
      y      <= '0;
      dcnt   <= '0;
      bias_q <= '0;
      for (int unsigned i = 0; i < KK; i++) wbank[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          n <= '0;
          k <= '0;
        end
        LOAD: begin
          if (k != 5'd0) wbank[k - 5'd1] <= bus.w_rdata;
          if (k == 5'd1) bias_q <= bus.b_rdata;
          if (k == 5'(KK)) begin
            k <= '0;
            x <= '0;
            y <= '0;
          end else begin
            k <= k + 5'd1;
          end
        end
        SCAN: begin
          dcnt <= '0;
          if (adv) begin
            if (last_y) begin
              y <= '0;
              x <= last_pos ? 5'd0 : x + 5'd1;
            end else begin
              y <= y + 5'd1;
            end
          end
        end
        DRAIN: if (adv) begin
          if (drain_end) begin
            dcnt <= '0;
            k    <= '0;
            if (!last_filter) n <= n + 3'd1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv <= '0;
      for (int unsigned i = 0; i < LAT; i++) da[i] <= '0;
    end else if (adv) begin
      dv[0] <= issue;
      da[0] <= issue_addr;
      for (int unsigned i = 1; i < LAT; i++) begin
        dv[i] <= dv[i-1];
        da[i] <= da[i-1];
      end
    end
  end
endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencer for the 5x5 convolution MAC (`mmu`) in the conv layer. On a start pulse it runs every filter of the layer in turn. For each filter it loads the 25 weights and the bias from synchronous weight/bias ROMs into a register bank. It then scans all output positions, issuing one window base address per cycle to the image-window fetch. A matching output address/valid is delayed to line up with the MAC result going to the output buffer. Back-pressure from the output buffer stalls the scan and the in-flight pipeline together.

## Interface
Parameters:
- DATA_W, 32, word width of weights, bias, pixels
- IMG_W, 32, input image row pitch in words
- KSIZE, 5, kernel side; bank holds KSIZE*KSIZE weights
- NUM_FILTER, 6, filters per layer
- OUT_ROW, 28, output rows
- OUT_COL, 28, output columns
- LAT, 2, cycles from win_valid issue to MAC result valid (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; one clock domain only
- start  in  1  start pulse; honoured only in IDLE
- out_ready  in  1  output buffer can accept; low stalls SCAN/DRAIN
- w_addr  out  8  weight ROM address (25*n+k)
- w_rdata  in  DATA_W  weight ROM data, valid 1 cycle after w_addr
- b_addr  out  3  bias ROM address (= n)
- b_rdata  in  DATA_W  bias ROM data, valid 1 cycle after b_addr
- weight_flat  out  25*DATA_W  weight k on bits [DATA_W*k +: DATA_W]
- bias_out  out  DATA_W  bias of current filter
- filter_idx  out  3  current filter n
- win_base  out  10  window top-left address x*IMG_W+y
- win_valid  out  1  win_base issued this cycle
- adv  out  1  pipeline advance enable for window fetch and MAC regs
- out_addr  out  13  output address n*OUT_ROW*OUT_COL + x*OUT_COL + y, aligned to result
- out_valid  out  1  result present at MAC output this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of layer

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD with n=0, k=0.
  - start while busy is ignored.
- LOAD, k=0..25, one step per cycle; out_ready is ignored:
  - k<25: w_addr=25*n+k.
  - k>=1: capture w_rdata into weight[k-1].
  - b_addr=n throughout; bias_out captured at k=1.
  - After k=25 -> SCAN with x=y=0.
- SCAN:
  - adv=out_ready.
  - On adv: win_valid=1 and win_base=x*IMG_W+y.
  - y increments; at y=OUT_COL-1, y wraps to 0 and x increments.
  - The issue at (OUT_ROW-1, OUT_COL-1) goes to DRAIN.
  - adv=0: counters hold and win_valid=0.
- DRAIN:
  - Lasts LAT advancing cycles (cycles with out_ready=1); no issue.
  - Weights and bias stay stable until the last result of the filter has left.
  - Then: n<NUM_FILTER-1 -> n++, LOAD k=0; otherwise -> DONE.
- DONE: done=1 for one cycle, then IDLE. weight_flat and bias_out keep their last values.
- Delay line: LAT-stage shift of {win_valid, out_addr}, shifting only when adv=1. out_valid/out_addr are the last stage.
- Outside SCAN/DRAIN, adv=0 and the delay line holds; it is empty by construction.
- Arithmetic is unsigned. Counter widths: n 3b, x/y 5b, k 5b. Addresses are computed from counters, not accumulated.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all counters, weight bank, bias_out and delay line are 0.
  - Every output is 0.
  - Applies mid-operation too; no result emerges after reset.
- start sampled in cycle t -> LOAD k=0 in t+1, busy=1 in t+1.
- With out_ready held 1, each filter takes 26 + OUT_ROW*OUT_COL + LAT cycles (812 with defaults).
- done at t+1+NUM_FILTER*812 = t+4873 with defaults; busy=0 from t+4874.
- First win_valid at t+27 with win_base=0. First out_valid at t+27+LAT with out_addr=0.
- out_valid count per layer is exactly NUM_FILTER*OUT_ROW*OUT_COL (4704). Addresses are strictly increasing by 1.
- A stall of s cycles anywhere in SCAN/DRAIN delays all later events by exactly s. No issue or result is lost or duplicated.
- start and out_ready=0 in the same IDLE cycle: start still accepted.

## Test plan
- Reset mid-operation: start, then rst_n=0 for 1 cycle at cycle 400 -> next cycle all outputs 0, IDLE; a later start runs a full layer normally.
- Weight load: ROM word i = i, bias j = 100+j, out_ready=1 -> at SCAN entry of filter 2, weight k=50+k and bias_out=102; at SCAN entry of filter 5, weight24=149 and bias_out=105.
- Row wrap: during SCAN, after win_base=27 (x=0,y=27) the next issue is 32. out_addr sequence shows 27 then 28, spaced one cycle apart.
- Stall: hold out_ready=0 for 10 cycles at cycle 300 -> win_valid and out_valid freeze, done moves from t+4873 to t+4883, all 4704 addresses appear exactly once in order.
- Layer end with checking model: golden conv over random 32x32 image vs out_addr-indexed captured MAC results -> all 4704 match. done is a single pulse; start during busy has no effect.
